bram18: RTL and testbench
=========================

Name: bram18

Overview:
- Simple dual-port, asymmetric-width block RAM, 16 Kbit total.
- Port A is a byte-wide write port: 2048 x 8.
- Port B is a word-wide read port: 512 x 32. Each 32-bit word is the concatenation of four consecutive port-A bytes.
- Used as a byte-ingest / word-readout buffer (e.g. pixel bytes packed into 32-bit words for the processing datapath).

Parameters:
- ADDRA_W, 11, port-A address width (byte depth 2^ADDRA_W = 2048)
- DINA_W, 8, port-A data width
- RATIO, 4, bytes per port-B word (power of two)
- Derived, not overridable: ADDRB_W = ADDRA_W - log2(RATIO) = 9; DOUTB_W = DINA_W*RATIO = 32

Ports:
- clk  in  1  single clock for both ports; rising-edge active
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  port-A enable
- wea  in  1  port-A write enable; effective only when ena=1
- addra  in  11  port-A byte address
- dina  in  8  port-A write data
- enb  in  1  port-B read enable
- addrb  in  9  port-B word address
- doutb  out  32  port-B registered read data

Behaviour:
- Write: on a rising edge with ena=1 and wea=1, mem_byte[addra] <= dina.
  - Any other combination of ena/wea: no write.
  - wea without ena is ignored.
- Byte packing is little-endian. doutb for word w is:
  - doutb[7:0] = byte {w,2'b00}
  - doutb[15:8] = byte {w,2'b01}
  - doutb[23:16] = byte {w,2'b10}
  - doutb[31:24] = byte {w,2'b11}
- Read: on a rising edge with enb=1, doutb <= word[addrb].
  - Latency is 1 cycle: the data is valid after the edge that samples addrb.
- enb=0: doutb holds its last value.
- Reset:
  - rst_n low asynchronously clears doutb to 32'h0 and holds it at 0 while asserted. No read takes effect during reset.
  - Memory contents are NOT cleared by reset. Writes are blocked while rst_n=0.
- Power-up contents are all zero (initial value, synthesis-inferable).
- Read/write collision (same edge, written byte lies inside the word being read) is read-first: doutb returns the pre-write byte. The new byte is visible on the next read.
- Address wrap: none needed. All 11-bit and 9-bit addresses are valid. Max byte 2047 maps to doutb[31:24] of word 511.
- No X propagation on doutb after reset, even if memory is uninitialised in a given tool.

Decomposition:
- Shared package bram18_pkg holds:
  - localparams ADDRA_W=11, DINA_W=8, RATIO=4, ADDRB_W=9, DOUTB_W=32
  - a function computing the lane index from addra[1:0]
- One sub-module, bram18_lane: a 512 x 8 simple dual-port RAM with write enable and read-first registered read.
- bram18 instantiates four lanes, indexed by addra[1:0] for write-lane select, with addra[10:2] as the lane address.
- Port B reads all four lanes at addrb in parallel and concatenates them.
- Reset of the output register lives in bram18 (the lane output itself is unreset).

Test Plan:
- Reset released, ena=1 wea=1 addra=0 dina=8'h03 for one edge; then enb=1 addrb=0 -> doutb=32'h00000003 one edge later.
- Write 8'h11, 8'h22, 8'h33, 8'h44 to addra 4..7; read addrb=1 -> doutb=32'h44332211. Then enb=0 with addrb=0 -> doutb stays 32'h44332211.
- Boundary: write 8'hAB to addra=2047, 8'hCD to addra=2044; read addrb=511 -> doutb=32'hAB0000CD.
- Gating: ena=0 wea=1 addra=8 dina=8'hFF, and separately ena=1 wea=0 dina=8'hEE; read addrb=2 -> 32'h00000000.
- Collision: word 3 holds 32'h00000000; same edge writes 8'h5A to addra=13 and reads addrb=3 -> doutb=32'h00000000; next read -> 32'h00005A00.
- Reset mid-operation: doutb=32'h44332211, assert rst_n=0 between edges -> doutb=0 immediately (before the next edge). Release and read addrb=1 -> 32'h44332211 (contents retained).

Source files
------------

// File: rtl/bram18_pkg.sv
// Shared sizing constants and lane-select helper for the 2048x8 / 512x32 block RAM.
package bram18_pkg;

    localparam int unsigned ADDRA_W = 11;
    localparam int unsigned DINA_W  = 8;
    localparam int unsigned RATIO   = 4;
    localparam int unsigned ADDRB_W = 9;
    localparam int unsigned DOUTB_W = 32;

    // Byte lane inside a port-B word for a given byte address (low address bits, little-endian).
    function automatic int unsigned lane_sel(input int unsigned byte_addr, input int unsigned ratio);
        return byte_addr % ratio;
    endfunction

endpackage

// File: rtl/bram18_lane.sv
// One byte lane: simple dual-port RAM, synchronous write, read-first registered read.
module bram18_lane #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1] = '{default: '0};
    logic [DATA_W-1:0] rd_d;
    logic [DATA_W-1:0] rd_q;

    // Byte write into the lane array.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Next read data: sample the pre-write array on a read, otherwise hold.
    always_comb begin
        rd_d = rd_q;
        if (re) begin
            rd_d = mem[raddr];
        end
    end

    // Unreset read register (kept reset-free so it maps onto the RAM output latch).
    always_ff @(posedge clk) begin
        rd_q <= rd_d;
    end

    assign rdata = rd_q;

endmodule

// File: rtl/bram18.sv
// Asymmetric block RAM: byte-wide write port A, word-wide read port B, four parallel byte lanes.
module bram18
    import bram18_pkg::*;
#(
    parameter  int unsigned ADDRA_W = bram18_pkg::ADDRA_W,
    parameter  int unsigned DINA_W  = bram18_pkg::DINA_W,
    parameter  int unsigned RATIO   = bram18_pkg::RATIO,
    localparam int unsigned ADDRB_W = ADDRA_W - $clog2(RATIO),
    localparam int unsigned DOUTB_W = DINA_W * RATIO
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               wea,
    input  logic [ADDRA_W-1:0] addra,
    input  logic [DINA_W-1:0]  dina,
    input  logic               enb,
    input  logic [ADDRB_W-1:0] addrb,
    output logic [DOUTB_W-1:0] doutb
);

    localparam int unsigned SEL_W = $clog2(RATIO);

    logic               wr_en;
    logic               rd_en;
    logic [RATIO-1:0]   lane_we;
    logic [DOUTB_W-1:0] rd_word;
    logic               valid_d;
    logic               valid_q;

    assign wr_en = ena & wea & rst_n;
    assign rd_en = enb & rst_n;

    // Steer the port-A write to the single lane selected by the low byte-address bits.
    always_comb begin
        lane_we = '0;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (lane_sel(32'(addra), RATIO) == i) begin
                lane_we[i] = wr_en;
            end
        end
    end

    for (genvar g = 0; g < RATIO; g++) begin : g_lane
        bram18_lane #(
            .ADDR_W (ADDRB_W),
            .DATA_W (DINA_W)
        ) u_lane (
            .clk   (clk),
            .we    (lane_we[g]),
            .waddr (addra[ADDRA_W-1:SEL_W]),
            .wdata (dina),
            .re    (rd_en),
            .raddr (addrb),
            .rdata (rd_word[g*DINA_W +: DINA_W])
        );
    end

    // Output-valid flag becomes set by the first read after reset and stays set.
    always_comb begin
        valid_d = valid_q | rd_en;
    end

    // The lane registers are unreset, so the async reset of the output is realised by
    // masking them with this reset flop; latency stays at one cycle and no X escapes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Registered read data, forced to zero until the first post-reset read.
    always_comb begin
        doutb = valid_q ? rd_word : '0;
    end

endmodule

// File: tb/tb_bram18.sv
// Directed self-checking bench for bram18.
module tb_bram18;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic        wea;
    logic [10:0] addra;
    logic [7:0]  dina;
    logic        enb;
    logic [8:0]  addrb;
    logic [31:0] doutb;

    int unsigned n_checks;
    int unsigned n_errors;

    bram18 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .wea   (wea),
        .addra (addra),
        .dina  (dina),
        .enb   (enb),
        .addrb (addrb),
        .doutb (doutb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled 1ns after it.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [10:0] a, input logic [7:0] d);
        ena = 1'b1; wea = 1'b1; addra = a; dina = d;
        cycle();
        ena = 1'b0; wea = 1'b0;
    endtask

    task automatic rd(input logic [8:0] a);
        enb = 1'b1; addrb = a;
        cycle();
        enb = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0; ena = 1'b0; wea = 1'b0; addra = '0; dina = '0; enb = 1'b0; addrb = '0;

        // write and read attempted while in reset: both must be blocked
        cycle();
        ena = 1'b1; wea = 1'b1; addra = 11'd16; dina = 8'h77; enb = 1'b1; addrb = 9'd4;
        cycle();
        check("reset_state", doutb, 32'h0000_0000);
        ena = 1'b0; wea = 1'b0; enb = 1'b0;
        cycle();
        rst_n = 1'b1;
        cycle();
        check("post_reset_idle", doutb, 32'h0000_0000);

        // first write then one-cycle-latency read
        wr(11'd0, 8'h03);
        rd(9'd0);
        check("first_read", doutb, 32'h0000_0003);

        // little-endian packing and hold with enb=0
        wr(11'd4, 8'h11);
        wr(11'd5, 8'h22);
        wr(11'd6, 8'h33);
        wr(11'd7, 8'h44);
        rd(9'd1);
        check("pack_word1", doutb, 32'h4433_2211);
        enb = 1'b0; addrb = 9'd0;
        cycle();
        check("hold_enb0", doutb, 32'h4433_2211);

        // top-of-memory boundary
        wr(11'd2047, 8'hAB);
        wr(11'd2044, 8'hCD);
        rd(9'd511);
        check("top_word", doutb, 32'hAB00_00CD);

        // write gating: wea without ena, ena without wea
        ena = 1'b0; wea = 1'b1; addra = 11'd8; dina = 8'hFF;
        cycle();
        ena = 1'b1; wea = 1'b0; addra = 11'd8; dina = 8'hEE;
        cycle();
        ena = 1'b0; wea = 1'b0;
        rd(9'd2);
        check("write_gating", doutb, 32'h0000_0000);

        // read-first collision inside word 3
        ena = 1'b1; wea = 1'b1; addra = 11'd13; dina = 8'h5A; enb = 1'b1; addrb = 9'd3;
        cycle();
        ena = 1'b0; wea = 1'b0; enb = 1'b0;
        check("collision_old", doutb, 32'h0000_0000);
        rd(9'd3);
        check("collision_new", doutb, 32'h0000_5A00);

        // asynchronous reset mid-operation
        rd(9'd1);
        check("pre_reset_word", doutb, 32'h4433_2211);
        #2 rst_n = 1'b0;
        #1 check("async_clear", doutb, 32'h0000_0000);
        enb = 1'b1; addrb = 9'd1;
        cycle();
        check("reset_hold", doutb, 32'h0000_0000);
        enb = 1'b0;
        rst_n = 1'b1;
        cycle();
        rd(9'd1);
        check("retained_word1", doutb, 32'h4433_2211);
        rd(9'd0);
        check("retained_word0", doutb, 32'h0000_0003);
        rd(9'd4);
        check("reset_write_blocked", doutb, 32'h0000_0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
